load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 1, range 1..15: memory read cycles from address valid to mem_rdata valid.
REQ-002 SHALL have ports: clk  input  1  system clock, rising edge active.
REQ-003 SHALL have ports: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: start  input  1  request strobe, sampled only in IDLE.
REQ-005 SHALL have ports: op  input  3  000 LW, 001 LH, 010 LB, 100 SW, 101 SH, 110 SB; other codes invalid.
REQ-006 SHALL have ports: addr  input  32  byte address.
REQ-007 SHALL have ports: store_data  input  32  store source; SB uses [7:0], SH uses [15:0].
REQ-008 SHALL have ports: mem_rdata  input  32  memory read word.
REQ-009 SHALL have ports: mem_addr  output  32  word-aligned address {addr[31:2],2'b00}.
REQ-010 SHALL have ports: mem_wr  output  1  memory write enable.
REQ-011 SHALL have ports: mem_wdata  output  32  memory write word.
REQ-012 SHALL have ports: load_size  output  32  zero-extended load result, feeds register write-data select.
REQ-013 SHALL have ports: busy  output  1  high in every state except IDLE.
REQ-014 SHALL have ports: done  output  1  one-cycle completion pulse.
REQ-015 SHALL have ports: error  output  1  misaligned or invalid op; valid only with done.

Function
REQ-016 SHALL use states IDLE, RD, WR, DONE.
REQ-017 SHALL latch op, addr and store_data on the clk edge where start=1 in IDLE.
REQ-018 SHALL ignore start in all states except IDLE; no queuing.
REQ-019 SHALL go IDLE->RD for LW/LH/LB/SH/SB, IDLE->WR for SW, and IDLE->DONE with error=1 for invalid op or misalignment (LW/SW addr[1:0]!=0; LH/SH addr[0]=1).
REQ-020 SHALL stay in RD exactly MEM_LATENCY cycles, counting with an internal counter, mem_wr=0, then capture mem_rdata on the final RD edge.
REQ-021 SHALL go RD->DONE for loads and RD->WR for SH/SB.
REQ-022 SHALL assert mem_wr for exactly one cycle in WR, then go to DONE.
REQ-023 SHALL go DONE->IDLE unconditionally after one cycle, with done=1 only in DONE.
REQ-024 SHALL use little-endian lanes: byte k = bits [8k+7:8k] with k=addr[1:0]; halfword h = bits [16h+15:16h] with h=addr[1].
REQ-025 SHALL set load_size to the word for LW, {16'b0, half h} for LH, {24'b0, byte k} for LB.
REQ-026 SHALL update load_size on the capture edge of successful loads only, and hold it otherwise (stores and errors included).
REQ-027 SHALL, for SW, drive mem_wdata=store_data.
REQ-028 SHALL, for SH/SB, drive mem_wdata = captured word with only lane h/k replaced by store_data[15:0]/[7:0]; other bytes unchanged.
REQ-029 SHALL hold mem_addr at the latched aligned address from the latch edge until the next accepted start.
REQ-030 SHALL keep error=0 when done=0, and SHALL never assert mem_wr or enter RD on an error request.
REQ-031 Latency from the start-sampling edge to done high: loads MEM_LATENCY+1 cycles, SH/SB MEM_LATENCY+2, SW 2, error 1.

Reset
REQ-032 SHALL, on reset=1, immediately force state IDLE, mem_wr=0, done=0, error=0, busy=0, load_size=0, mem_addr=0, mem_wdata=0 and counter=0, independent of clk.
REQ-033 SHALL, on reset during RD or WR, abort the transfer with no further mem_wr and no done pulse.
REQ-034 SHALL accept start on the first clk edge after reset deasserts.

Verification
REQ-035 LB, addr=0x00000103, mem_rdata=0xAABBCCDD, MEM_LATENCY=1 -> mem_addr=0x00000100, done 2 cycles after start, load_size=0x000000AA, mem_wr never high.
REQ-036 SH, addr=0x00000012, store_data=0x12345678, mem_rdata=0xAABBCCDD -> one mem_wr pulse, mem_wdata=0x5678CCDD, mem_addr=0x00000010, done 3 cycles after start.
REQ-037 LW addr=0x00000006 -> done=1 and error=1 one cycle after start, busy never high in RD/WR, mem_wr=0, load_size unchanged.
REQ-038 MEM_LATENCY=3, LH addr=0x00000020, mem_rdata=0x0000BEEF -> busy 4 cycles, load_size=0x0000BEEF; start pulses while busy ignored.
REQ-039 SB started, reset asserted mid-RD -> outputs zero immediately, no mem_wr, no done; subsequent SW addr=0x4, store_data=0xCAFEBABE -> mem_wdata=0xCAFEBABE, done 2 cycles after start.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store sequencer between the core and a fixed-latency word memory.
// Handles LW/LH/LB and SW/SH/SB, doing read-modify-write for sub-word stores.
module load_store_unit #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic [31:0] load_size,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  lane_q, lane_d;
    logic [15:0] sdata_q, sdata_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] load_size_q, load_size_d;
    logic        err_q, err_d;

    // op[2] selects store; op[1:0] is the access size, with 2'b11 unused
    logic        req_invalid;
    logic        req_misaligned;
    logic [4:0]  shamt;
    logic [31:0] rd_shifted;
    logic [31:0] lane_mask;
    logic [31:0] merged_word;
    logic [31:0] load_word;

    assign req_invalid    = (op[1:0] == 2'b11);
    assign req_misaligned = ((op[1:0] == 2'b00) && (addr[1:0] != 2'b00)) ||
                            ((op[1:0] == 2'b01) && addr[0]);

    assign shamt       = {lane_q, 3'b000};
    assign rd_shifted  = mem_rdata >> shamt;
    assign lane_mask   = (op_q[1:0] == 2'b01) ? (32'h0000_FFFF << shamt)
                                              : (32'h0000_00FF << shamt);
    assign merged_word = (mem_rdata & ~lane_mask) |
                         (({16'h0000, sdata_q} << shamt) & lane_mask);

    always_comb begin
        case (op_q[1:0])
            2'b00:   load_word = mem_rdata;
            2'b01:   load_word = {16'h0000, rd_shifted[15:0]};
            default: load_word = {24'h00_0000, rd_shifted[7:0]};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= 3'b000;
            lane_q      <= 2'b00;
            sdata_q     <= 16'h0000;
            cnt_q       <= 4'd0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            load_size_q <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            lane_q      <= lane_d;
            sdata_q     <= sdata_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            load_size_q <= load_size_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        lane_d      = lane_q;
        sdata_d     = sdata_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        load_size_d = load_size_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d       = op;
                    lane_d     = addr[1:0];
                    sdata_d    = store_data[15:0];
                    mem_addr_d = {addr[31:2], 2'b00};
                    err_d      = 1'b0;
                    if (req_invalid || req_misaligned) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (op == 3'b100) begin
                        mem_wdata_d = store_data;
                        state_d     = WR;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (cnt_q == 4'd0) begin
                    if (op_q[2]) begin
                        mem_wdata_d = merged_word;
                        state_d     = WR;
                    end else begin
                        load_size_d = load_word;
                        state_d     = DONE;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign load_size = load_size_q;
    assign mem_wr    = (state_q == WR);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign error     = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Drives two load/store units (memory latency 1 and 3) with the same requests
// and compares both against a per-transaction arithmetic model of the access.
module tb_load_store_unit;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] rdata_v [2];

    wire  [1:0]  busy_v, done_v, err_v, wr_v;
    wire  [31:0] maddr_v [2];
    wire  [31:0] wdata_v [2];
    wire  [31:0] ls_v    [2];

    int checks = 0;
    int errors = 0;
    logic [31:0] ls_model [2];

    always #5 clk = ~clk;

    load_store_unit #(.MEM_LATENCY(LAT_A)) u_dut_a (
        .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr),
        .store_data(store_data), .mem_rdata(rdata_v[0]), .mem_addr(maddr_v[0]),
        .mem_wr(wr_v[0]), .mem_wdata(wdata_v[0]), .load_size(ls_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .error(err_v[0])
    );

    load_store_unit #(.MEM_LATENCY(LAT_B)) u_dut_b (
        .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr),
        .store_data(store_data), .mem_rdata(rdata_v[1]), .mem_addr(maddr_v[1]),
        .mem_wr(wr_v[1]), .mem_wdata(wdata_v[1]), .load_size(ls_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .error(err_v[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string pre);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_maddr%0d", pre, d), maddr_v[d], 32'h0);
            check($sformatf("%s_wdata%0d", pre, d), wdata_v[d], 32'h0);
            check($sformatf("%s_ls%0d", pre, d), ls_v[d], 32'h0);
            check($sformatf("%s_ctl%0d", pre, d),
                  32'({busy_v[d], done_v[d], err_v[d], wr_v[d]}), 32'h0);
        end
    endtask

    // One request; the memory model presents the word only in the cycle
    // MEM_LATENCY after the address became valid, random data otherwise.
    task automatic txn(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] word);
        int          sz;
        int          k;
        int          shift;
        bit          bad;
        bit          is_store;
        logic [31:0] lane_mask;
        logic [31:0] exp_load;
        logic [31:0] exp_wdata;
        int          exp_lat [2];
        int          max_lat;
        int          done_cyc [2];
        int          done_cnt [2];
        int          wr_cnt [2];
        int          busy_bad [2];
        int          err_bad [2];
        logic [31:0] wd_seen [2];
        logic [31:0] err_at_done [2];
        logic [31:0] ls_at_done [2];
        logic [31:0] maddr_at_done [2];

        sz       = int'(o[1:0]);
        k        = int'(a[1:0]);
        is_store = o[2];
        bad      = (sz == 3) || (sz == 0 && k != 0) || (sz == 1 && a[0]);
        shift    = (sz == 1) ? 16 * (k / 2) : (sz == 2) ? 8 * k : 0;
        lane_mask = (sz == 0) ? 32'hFFFF_FFFF :
                    (sz == 1) ? (32'h0000_FFFF << shift) : (32'h0000_00FF << shift);
        exp_load  = (word & lane_mask) >> shift;
        exp_wdata = (o == 3'b100) ? sd : ((word & ~lane_mask) | ((sd << shift) & lane_mask));

        for (int d = 0; d < 2; d++) begin
            int lat;
            lat = (d == 0) ? LAT_A : LAT_B;
            if (bad)            exp_lat[d] = 1;
            else if (!is_store) exp_lat[d] = lat + 1;
            else if (sz == 0)   exp_lat[d] = 2;
            else                exp_lat[d] = lat + 2;
            done_cyc[d] = 0; done_cnt[d] = 0; wr_cnt[d] = 0;
            busy_bad[d] = 0; err_bad[d] = 0;
            wd_seen[d] = 32'h0; err_at_done[d] = 32'h0;
            ls_at_done[d] = 32'h0; maddr_at_done[d] = 32'h0;
        end
        max_lat = (exp_lat[0] > exp_lat[1]) ? exp_lat[0] : exp_lat[1];

        @(negedge clk);
        op = o; addr = a; store_data = sd; start = 1'b1;
        rdata_v[0] = $urandom; rdata_v[1] = $urandom;

        for (int c = 1; c <= max_lat + 1; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (done_v[d]) begin
                    done_cnt[d]++;
                    if (done_cyc[d] == 0) done_cyc[d] = c;
                    err_at_done[d]   = 32'(err_v[d]);
                    ls_at_done[d]    = ls_v[d];
                    maddr_at_done[d] = maddr_v[d];
                end else if (err_v[d]) begin
                    err_bad[d]++;
                end
                if (wr_v[d]) begin
                    wr_cnt[d]++;
                    wd_seen[d] = wdata_v[d];
                end
                if (busy_v[d] != (c <= exp_lat[d])) busy_bad[d]++;
            end
            // a second request while busy must be dropped, and the latched
            // request must not follow the live inputs
            if (c == 1) begin
                start = 1'b1; op = 3'($urandom); addr = $urandom; store_data = $urandom;
            end else begin
                start = 1'b0;
            end
            rdata_v[0] = (c == LAT_A) ? word : $urandom;
            rdata_v[1] = (c == LAT_B) ? word : $urandom;
        end

        for (int d = 0; d < 2; d++) begin
            if (!bad && !is_store) ls_model[d] = exp_load;
            check($sformatf("lat%0d", d), 32'(done_cyc[d]), 32'(exp_lat[d]));
            check($sformatf("done_pulses%0d", d), 32'(done_cnt[d]), 32'd1);
            check($sformatf("error%0d", d), err_at_done[d], 32'(bad));
            check($sformatf("wr_pulses%0d", d), 32'(wr_cnt[d]), 32'(!bad && is_store));
            if (!bad && is_store) check($sformatf("wdata%0d", d), wd_seen[d], exp_wdata);
            check($sformatf("maddr%0d", d), maddr_at_done[d], a & 32'hFFFF_FFFC);
            check($sformatf("load_size%0d", d), ls_at_done[d], ls_model[d]);
            check($sformatf("busy_shape%0d", d), 32'(busy_bad[d]), 32'd0);
            check($sformatf("err_no_done%0d", d), 32'(err_bad[d]), 32'd0);
            check($sformatf("maddr_hold%0d", d), maddr_v[d], a & 32'hFFFF_FFFC);
            check($sformatf("ls_hold%0d", d), ls_v[d], ls_model[d]);
        end
    endtask

    initial begin
        int stray;
        reset = 1'b1; start = 1'b0; op = 3'b000; addr = 32'h0; store_data = 32'h0;
        rdata_v[0] = 32'h0; rdata_v[1] = 32'h0;
        ls_model[0] = 32'h0; ls_model[1] = 32'h0;
        #2;
        check_zero("por");
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;

        txn(3'b010, 32'h0000_0103, 32'h0, 32'hAABB_CCDD);          // LB
        txn(3'b101, 32'h0000_0012, 32'h1234_5678, 32'hAABB_CCDD);  // SH
        txn(3'b000, 32'h0000_0006, 32'h0, 32'h1111_2222);          // LW misaligned
        txn(3'b001, 32'h0000_0020, 32'h0, 32'h0000_BEEF);          // LH
        txn(3'b011, 32'h0000_0040, 32'h0, 32'h3333_4444);          // invalid op
        txn(3'b101, 32'h0000_0041, 32'h0, 32'h5555_6666);          // SH misaligned

        // reset in the middle of a sub-word store read phase
        @(negedge clk);
        op = 3'b110; addr = 32'h0000_0041; store_data = $urandom; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        #1;
        check_zero("rst_rd");
        ls_model[0] = 32'h0; ls_model[1] = 32'h0;
        stray = 0;
        repeat (2) begin
            @(negedge clk);
            stray += int'(wr_v[0]) + int'(wr_v[1]) + int'(done_v[0]) + int'(done_v[1]);
        end
        check("rst_no_activity", 32'(stray), 32'd0);
        @(posedge clk);
        #3 reset = 1'b0;
        txn(3'b100, 32'h0000_0004, 32'hCAFE_BABE, 32'h0);          // SW right after reset

        for (int i = 0; i < 200; i++) begin
            logic [31:0] ra;
            ra = $urandom;
            if ($urandom_range(0, 3) != 0) ra[0] = 1'b0;
            if ($urandom_range(0, 3) == 0) ra[1:0] = 2'b00;
            txn(3'($urandom_range(0, 7)), ra, $urandom, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
